// File: rtl/clock_divider_multi.sv
// Multi-channel clock divider with staged, glitch-free divisor reload and sync.
// Define CLOCK_DIVIDER_PERIOD_COUNT_EN to add per-channel tick counters.
module clock_divider_multi #(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int CHAN_W      = 2,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  enable,
  input  logic                 sync,
  input  logic                 wr_en,
  input  logic [CHAN_W-1:0]    wr_chan,
  input  logic [DIV_WIDTH-1:0] wr_div,
`ifdef CLOCK_DIVIDER_PERIOD_COUNT_EN
  input  logic [CHAN_W-1:0]    rd_chan,
  output logic [15:0]          period_count,
`endif
  output logic [CHANNELS-1:0]  pending,
  output logic [CHANNELS-1:0]  d_clock,
  output logic [CHANNELS-1:0]  tick
);

  typedef logic [DIV_WIDTH-1:0] div_t;

  localparam div_t ZERO = '0;
  localparam div_t ONE  = div_t'(1);
  localparam div_t TWO  = div_t'(2);
  localparam div_t DEF  = div_t'(DEFAULT_DIV);

  div_t div_q [CHANNELS];
  div_t div_d [CHANNELS];
  div_t cnt_q [CHANNELS];
  div_t cnt_d [CHANNELS];
  div_t stg_q [CHANNELS];
  div_t stg_d [CHANNELS];
  div_t dnew  [CHANNELS];

  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] dclk_q, dclk_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] hit, last, app;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i]    = wr_en && (wr_chan == CHAN_W'(i));
      last[i]   = (div_q[i] >= TWO) && (cnt_q[i] == div_q[i] - ONE);
      app[i]    = pend_q[i] &&
                  (!enable[i] || div_q[i] < TWO || last[i] || sync);
      dnew[i]   = app[i] ? stg_q[i] : div_q[i];
      div_d[i]  = dnew[i];
      stg_d[i]  = hit[i] ? wr_div : stg_q[i];
      // a same-edge write re-arms pending after the old value is applied
      pend_d[i] = hit[i] | (pend_q[i] & ~app[i]);
      tick_d[i] = 1'b0;
      dclk_d[i] = 1'b0;
      cnt_d[i]  = ZERO;
      if (!enable[i]) begin
        cnt_d[i] = ZERO;
      end else if (sync) begin
        tick_d[i] = 1'b1;
        dclk_d[i] = (dnew[i] != ZERO);
        cnt_d[i]  = (dnew[i] >= TWO) ? ONE : ZERO;
      end else if (div_q[i] == ZERO) begin
        cnt_d[i] = ZERO;
      end else if (div_q[i] == ONE) begin
        tick_d[i] = 1'b1;
        dclk_d[i] = 1'b1;
      end else begin
        tick_d[i] = (cnt_q[i] == ZERO);
        dclk_d[i] = (cnt_q[i] < (div_q[i] >> 1));
        cnt_d[i]  = last[i] ? ZERO : cnt_q[i] + ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i] <= DEF;
        cnt_q[i] <= ZERO;
        stg_q[i] <= DEF;
      end
      pend_q <= '0;
      dclk_q <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
        stg_q[i] <= stg_d[i];
      end
      pend_q <= pend_d;
      dclk_q <= dclk_d;
      tick_q <= tick_d;
    end
  end

  assign pending = pend_q;
  assign d_clock = dclk_q;
  assign tick    = tick_q;

`ifdef CLOCK_DIVIDER_PERIOD_COUNT_EN
  logic [15:0] pc_q [CHANNELS];
  logic [15:0] pc_d [CHANNELS];
  logic [15:0] rd_q, rd_d;

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pc_d[i] = sync ? 16'd0 : pc_q[i] + 16'(tick_d[i]);
      if (rd_chan == CHAN_W'(i)) rd_d = pc_q[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) pc_q[i] <= '0;
      rd_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) pc_q[i] <= pc_d[i];
      rd_q <= rd_d;
    end
  end

  assign period_count = rd_q;
`endif

endmodule
